// File: rtl/r88_mem_arb.sv
// r88_mem_arb - two-port (CPU / DMA) round-robin arbiter for a single
// asynchronous-style memory bus with optional wait states.
//
// Ports
//   sysClock, sysReset             clock, async active-high reset
//   cpuReq/We/Addr/WData           CPU request side
//   cpuAck, cpuRData               CPU one-cycle completion pulse, read data
//   dmaReq/We/Addr/WData           DMA request side
//   dmaAck, dmaRData               DMA completion pulse, read data
//   memA, memDOut, memDIn          memory address, write data, read data
//   readMem, writeMem              memory strobes, held for the whole access
//   busOwner                       0 = CPU, 1 = DMA
//   waitStates                     extra access cycles (used only with the macro)
//
// Build option
//   R88_MEM_ARB_WAIT_EN  when defined, each access lasts 1 + waitStates cycles
//                        (sampled at grant); otherwise every access is 1 cycle
//                        and waitStates is ignored.
//
// State table
//   state     | meaning
//   ST_IDLE   | bus free, sampling requests
//   ST_ACCESS | strobe asserted towards memory, wait counter running
//   ST_DONE   | Ack has been pulsed, one recovery cycle before next grant

module r88_mem_arb (
    input  logic        sysClock,
    input  logic        sysReset,

    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [15:0] cpuAddr,
    input  logic [7:0]  cpuWData,
    output logic        cpuAck,
    output logic [7:0]  cpuRData,

    input  logic        dmaReq,
    input  logic        dmaWe,
    input  logic [15:0] dmaAddr,
    input  logic [7:0]  dmaWData,
    output logic        dmaAck,
    output logic [7:0]  dmaRData,

    output logic [15:0] memA,
    output logic [7:0]  memDOut,
    input  logic [7:0]  memDIn,
    output logic        readMem,
    output logic        writeMem,

    output logic        busOwner,
    input  logic [1:0]  waitStates
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]  state;
    logic        last_grant;     // 0 = CPU, 1 = DMA
    logic        any_req;
    logic        pick_dma;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        access_last;

    // DMA wins only if it is alone, or on a tie when the CPU was granted last.
    always_comb begin
        any_req   = cpuReq | dmaReq;
        pick_dma  = dmaReq & (~cpuReq | ~last_grant);
        sel_we    = pick_dma ? dmaWe    : cpuWe;
        sel_addr  = pick_dma ? dmaAddr  : cpuAddr;
        sel_wdata = pick_dma ? dmaWData : cpuWData;
    end

`ifdef R88_MEM_ARB_WAIT_EN
    logic [1:0] wait_cnt;

    always_ff @(posedge sysClock or posedge sysReset) begin
        if (sysReset) begin
            wait_cnt <= 2'd0;
        end else if (state == ST_IDLE && any_req) begin
            wait_cnt <= waitStates;
        end else if (state == ST_ACCESS && wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
        end
    end

    assign access_last = (wait_cnt == 2'd0);
`else
    logic unused_wait;
    assign unused_wait = ^waitStates;
    assign access_last = 1'b1;
`endif

    always_ff @(posedge sysClock or posedge sysReset) begin
        if (sysReset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            memA       <= 16'h0000;
            memDOut    <= 8'h00;
            readMem    <= 1'b0;
            writeMem   <= 1'b0;
            busOwner   <= 1'b0;
            cpuAck     <= 1'b0;
            dmaAck     <= 1'b0;
            cpuRData   <= 8'h00;
            dmaRData   <= 8'h00;
        end else begin
            // Acks are single-cycle pulses unless re-asserted below.
            cpuAck <= 1'b0;
            dmaAck <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        memA       <= sel_addr;
                        memDOut    <= sel_wdata;
                        busOwner   <= pick_dma;
                        last_grant <= pick_dma;
                        readMem    <= ~sel_we;
                        writeMem   <= sel_we;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (access_last) begin
                        readMem  <= 1'b0;
                        writeMem <= 1'b0;
                        if (readMem) begin
                            if (busOwner) dmaRData <= memDIn;
                            else          cpuRData <= memDIn;
                        end
                        if (busOwner) dmaAck <= 1'b1;
                        else          cpuAck <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/r88_mem_arb.md
R88_MEM_ARB -- requirements
Module: r88_mem_arb

Interface
REQ-001 SHALL have port: sysClock  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: sysReset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: cpuReq in 1 request; cpuWe in 1 write(1)/read(0); cpuAddr in 16 address; cpuWData in 8 write data.
REQ-004 SHALL have ports: cpuAck out 1 one-cycle completion pulse; cpuRData out 8 read data.
REQ-005 SHALL have ports: dmaReq, dmaWe, dmaAddr, dmaWData, dmaAck and dmaRData, identical in direction, width and meaning to the cpu* ports.
REQ-006 SHALL have ports: memA out 16 bus address; memDOut out 8 write data; memDIn in 8 read data; readMem out 1; writeMem out 1.
REQ-007 SHALL have ports: busOwner out 1 (0=CPU, 1=DMA, valid while an access is in progress); waitStates in 2 extra access cycles.

Function
REQ-008 SHALL implement the FSM states IDLE, ACCESS and DONE; all outputs are registered.
REQ-009 IDLE, no request: SHALL remain in IDLE with readMem=writeMem=0.
REQ-010 IDLE, one request: SHALL grant it at the next edge and go to ACCESS.
REQ-011 IDLE, both requesting: SHALL grant the requester not granted last (round-robin); lastGrant resets to DMA, so the CPU wins the first tie.
REQ-012 On grant: SHALL latch addr/we/wdata into memA/memDOut, set busOwner, and assert readMem (we=0) or writeMem (we=1) in the same edge.
REQ-013 readMem/writeMem SHALL be mutually exclusive and held constant for the whole ACCESS phase.
REQ-014 ACCESS SHALL last 1+W cycles, where W is the wait-state count (see Configuration); an internal 2-bit counter counts down to 0.
REQ-015 Last ACCESS edge, read: SHALL capture memDIn into the granted port's RData.
REQ-016 Last ACCESS edge, both read and write: SHALL drop readMem/writeMem, pulse the granted port's Ack for exactly one cycle, and go to DONE.
REQ-017 DONE SHALL go to IDLE unconditionally at the next edge; minimum request-sample-to-Ack latency is 2 edges (W=0).
REQ-018 A requester SHALL hold Req/We/Addr/WData stable until it sees Ack, and SHALL deassert Req no later than the edge after Ack; a Req still high in IDLE is a new request.
REQ-019 Req deasserted mid-access: the access SHALL still complete and Ack SHALL still pulse.
REQ-020 RData SHALL hold its value until that port's next read completes; the other port's RData and Ack SHALL be unaffected.
REQ-021 memA/memDOut SHALL hold their last values in IDLE/DONE; back-to-back ownership switches SHALL go through DONE and IDLE.

Reset
REQ-022 sysReset high SHALL immediately force: state=IDLE; lastGrant=DMA; wait counter=0; and all outputs zero (memA=0, memDOut=0, readMem=writeMem=0, busOwner=0, cpuAck=dmaAck=0, cpuRData=dmaRData=0).
REQ-023 Reset mid-ACCESS SHALL abort the access with no Ack; after release the FSM samples requests afresh in IDLE.

Configuration
REQ-024 With macro R88_MEM_ARB_WAIT_EN defined, W SHALL equal waitStates, sampled at grant and held for that access.
REQ-025 Without R88_MEM_ARB_WAIT_EN, W SHALL be 0, waitStates SHALL be ignored, and the wait counter SHALL be omitted.

Verification
REQ-026 CPU read only, cpuAddr=16'h1234, memDIn=8'hA5, W=0 -> readMem high for exactly 1 cycle with memA=16'h1234; cpuAck pulses 2 edges after the request is sampled; cpuRData=8'hA5.
REQ-027 DMA write only, dmaAddr=16'h8000, dmaWData=8'h3C -> writeMem high for 1 cycle, memDOut=8'h3C, busOwner=1; dmaAck pulses once.
REQ-028 cpuReq and dmaReq held continuously from reset -> grants alternate CPU, DMA, CPU, DMA; never two consecutive grants to one side.
REQ-029 With R88_MEM_ARB_WAIT_EN defined, waitStates=3, CPU read -> readMem high for 4 cycles; memDIn captured only on the 4th; Ack pulses 5 edges after sampling.
REQ-030 sysReset asserted during the 2nd cycle of a W=2 access -> readMem drops immediately, no Ack, all outputs 0; after release a pending dmaReq is granted normally.
